// File: rtl/eqv_sweep_checker.sv
// eqv_sweep_checker
//
// Sweeps every K-bit input vector, in ascending order, into an external
// combinational block. For each vector it compares M reference outputs against
// M alternative-form outputs. It counts failing vectors, captures the first
// failure, and reports pass/fail once the sweep completes.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   start           begin a sweep; honoured only in IDLE or DONE
//   vec_out         vector currently applied to the block under test (MSB = input A)
//   ref_in          reference outputs for vec_out
//   dut_in          alternative-form outputs for vec_out
//   busy            high while a sweep is in progress (APPLY/CHECK)
//   done            high after a completed sweep, until restart or reset
//   pass            valid while done=1; 1 iff no vector mismatched
//   err_count       number of mismatching vectors (K+1 bits, holds 2^K)
//   fail_valid      a mismatch has been captured in first_fail_*
//   first_fail_vec  vector of the first mismatch
//   first_fail_mask ref_in ^ dut_in at the first mismatch

module eqv_sweep_checker #(
    parameter int unsigned K      = 4,
    parameter int unsigned M      = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [K-1:0] vec_out,
    input  logic [M-1:0] ref_in,
    input  logic [M-1:0] dut_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [K:0]   err_count,
    output logic         fail_valid,
    output logic [K-1:0] first_fail_vec,
    output logic [M-1:0] first_fail_mask
);

    // Wide enough to hold the value SETTLE itself.
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
    localparam logic [K-1:0]    VecLast = {K{1'b1}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StApply = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [K-1:0]    vec_q, vec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [K:0]      err_q, err_d;
    logic            fv_q, fv_d;
    logic [K-1:0]    ffv_q, ffv_d;
    logic [M-1:0]    ffm_q, ffm_d;
    logic [M-1:0]    mm;

    assign mm = ref_in ^ dut_in;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StApply;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffv_d   = '0;
                    ffm_d   = '0;
                end
            end
            StApply: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mm != '0) begin
                    // At most 2^K increments per sweep, so K+1 bits never wrap.
                    err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffv_d = vec_q;
                        ffm_d = mm;
                    end
                end
                if (vec_q == VecLast) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StApply;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
            ffm_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffv_q   <= ffv_d;
            ffm_q   <= ffm_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = (state_q == StApply) || (state_q == StCheck);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign fail_valid      = fv_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_eqv_sweep_checker.sv
module tb_eqv_sweep_checker;

    typedef struct {
        logic [4:0] err;
        logic       fv;
        logic [3:0] ffv;
        logic [2:0] ffm;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;

    logic [3:0] vec1, vec3, ffv1, ffv3;
    logic [2:0] ref1, ref3, dut1, dut3, ffm1, ffm3;
    logic [4:0] err1, err3;
    logic       busy1, busy3, done1, done3, pass1, pass3, fv1, fv3;

    int  mode = 0;
    bit  glitch = 1'b0;
    bit  sel3 = 1'b0;
    int  n_checks = 0;
    int  n_bad = 0;
    exp_t sb[$];

    // Muxed view of whichever instance the current scenario drives.
    logic [3:0] o_vec, o_ffv;
    logic [2:0] o_ffm;
    logic [4:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;
    assign o_vec  = sel3 ? vec3  : vec1;
    assign o_ffv  = sel3 ? ffv3  : ffv1;
    assign o_ffm  = sel3 ? ffm3  : ffm1;
    assign o_err  = sel3 ? err3  : err1;
    assign o_busy = sel3 ? busy3 : busy1;
    assign o_done = sel3 ? done3 : done1;
    assign o_pass = sel3 ? pass3 : pass1;
    assign o_fv   = sel3 ? fv3   : fv1;

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_fn(input logic [3:0] v);
        return {v[3] ^ v[0], v[2] & v[1], v[3] | v[1]};
    endfunction

    function automatic logic [2:0] dut_fn(input logic [3:0] v, input int md, input bit g);
        logic [2:0] r;
        r = ref_fn(v);
        case (md)
            1:       return r ^ (((v == 4'd5) || (v == 4'd9)) ? 3'b010 : 3'b000);
            2:       return ~r;
            3:       return r ^ (g ? 3'b111 : 3'b000);
            default: return r;
        endcase
    endfunction

    assign ref1 = ref_fn(vec1);
    assign dut1 = dut_fn(vec1, mode, glitch);
    assign ref3 = ref_fn(vec3);
    assign dut3 = dut_fn(vec3, mode, glitch);

    eqv_sweep_checker #(.K(4), .M(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .vec_out(vec1),
        .ref_in(ref1), .dut_in(dut1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .first_fail_vec(ffv1),
        .first_fail_mask(ffm1)
    );

    eqv_sweep_checker #(.K(4), .M(3), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec_out(vec3),
        .ref_in(ref3), .dut_in(dut3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .first_fail_vec(ffv3),
        .first_fail_mask(ffm3)
    );

    // Expected results come from the bench's own model of the sweep: only values
    // sampled in CHECK count, so mode 3 (glitches during APPLY only) never fails.
    function automatic exp_t model(input int md);
        exp_t x;
        logic [2:0] m;
        x.err = '0; x.fv = 1'b0; x.ffv = '0; x.ffm = '0;
        for (int v = 0; v < 16; v++) begin
            m = ref_fn(4'(v)) ^ dut_fn(4'(v), md, 1'b0);
            if (m != 3'b000) begin
                x.err = x.err + 5'd1;
                if (!x.fv) begin
                    x.fv = 1'b1; x.ffv = 4'(v); x.ffm = m;
                end
            end
        end
        x.pass = (x.err == 5'd0);
        return x;
    endfunction

    // One full sweep; vec_out/busy/done are checked after every edge and the
    // final results against the scoreboard entry pushed at start.
    task automatic run_sweep(input bit use3, input int md, input bit hold);
        int s;
        int last;
        exp_t x;
        s = use3 ? 3 : 1;
        last = 16 * (s + 1);
        sel3 = use3;
        mode = md;
        glitch = 1'b0;
        sb.push_back(model(md));
        @(negedge clk);
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
        glitch = (md == 3) && ((1 % (s + 1)) != 0);
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            #1;
            if (e < last) begin
                n_checks++;
                if (o_vec !== 4'(e / (s + 1)) || o_busy !== 1'b1 || o_done !== 1'b0
                    || o_pass !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sweep_step s=%0d e=%0d: vec=%0d busy=%b done=%b pass=%b, want vec=%0d busy=1 done=0 pass=0",
                             s, e, o_vec, o_busy, o_done, o_pass, e / (s + 1));
                end
            end else begin
                n_checks++;
                if (o_done !== 1'b1 || o_busy !== 1'b0 || o_vec !== 4'd15) begin
                    n_bad++;
                    $display("FAIL sweep_done s=%0d: done=%b busy=%b vec=%0d, want done=1 busy=0 vec=15",
                             s, o_done, o_busy, o_vec);
                end
                n_checks++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_empty: got 0 entries, want 1");
                end else begin
                    x = sb.pop_front();
                    if (o_err !== x.err || o_fv !== x.fv || o_ffv !== x.ffv
                        || o_ffm !== x.ffm || o_pass !== x.pass) begin
                        n_bad++;
                        $display("FAIL results mode=%0d: err=%0d fv=%b ffv=%0d ffm=%b pass=%b, want err=%0d fv=%b ffv=%0d ffm=%b pass=%b",
                                 md, o_err, o_fv, o_ffv, o_ffm, o_pass,
                                 x.err, x.fv, x.ffv, x.ffm, x.pass);
                    end
                end
            end
            glitch = (md == 3) && (((e + 1) % (s + 1)) != 0);
        end
        glitch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_checks++;
        if ({vec1, busy1, done1, pass1, err1, fv1, ffv1, ffm1} !== '0
            || {vec3, busy3, done3, pass3, err3, fv3, ffv3, ffm3} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: dut1 vec=%0d busy=%b done=%b err=%0d fv=%b, want all 0",
                     vec1, busy1, done1, err1, fv1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy1, done1);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        sel3 = 1'b0;
        mode = 0;
        seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (vec1 == 4'd7) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_bad++;
            $display("FAIL mid_reset_wait: vec never reached 7 (vec=%0d), want 7", vec1);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({vec1, busy1, done1, pass1, err1, fv1, ffv1, ffm1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_async: vec=%0d busy=%b done=%b err=%0d fv=%b, want all 0",
                     vec1, busy1, done1, err1, fv1);
        end
        @(negedge clk);
        reset = 1'b1;
        run_sweep(1'b0, 1, 1'b0);
    endtask

    task automatic test_hold_start();
        run_sweep(1'b0, 1, 1'b1);
        // start is still high in DONE: the next edge must restart cleanly.
        @(posedge clk);
        #1;
        n_checks++;
        if (vec1 !== 4'd0 || done1 !== 1'b0 || busy1 !== 1'b1 || err1 !== 5'd0
            || fv1 !== 1'b0 || ffv1 !== 4'd0 || ffm1 !== 3'd0) begin
            n_bad++;
            $display("FAIL restart_from_done: vec=%0d done=%b busy=%b err=%0d fv=%b, want 0 0 1 0 0",
                     vec1, done1, busy1, err1, fv1);
        end
        start1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        run_sweep(1'b0, 0, 1'b0);   // all equal
        run_sweep(1'b0, 1, 1'b0);   // mismatches at 5 and 9
        run_sweep(1'b0, 2, 1'b0);   // all fail, err_count = 16
        run_sweep(1'b0, 0, 1'b0);   // back-to-back restart from DONE
        test_mid_reset();
        test_hold_start();
        run_sweep(1'b1, 3, 1'b0);   // SETTLE=3, glitches only during APPLY
        run_sweep(1'b1, 1, 1'b0);   // SETTLE=3, real mismatches
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
